// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-producer skid FIFOs, round-robin grant onto NUM_BUS registered lanes.
// Optional feature: define CDB_BYPASS_EN to let an empty FIFO forward its incoming result straight to a lane.
module cdb_arbiter #(
  parameter int NUM_SRC    = 6,
  parameter int NUM_BUS    = 2,
  parameter int ROB_DEPTH  = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_SRC-1:0]              src_valid,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]   src_tag,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data,
  output logic [NUM_BUS-1:0]              bus_valid,
  output logic [NUM_BUS-1:0][TAG_W-1:0]   bus_tag,
  output logic [NUM_BUS-1:0][DATA_W-1:0]  bus_data,
  output logic [ROB_DEPTH-1:0]            rob_set_valid
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [TAG_W-1:0]  fifo_tag  [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr    [NUM_SRC];
  logic [PTR_W-1:0]  wr_ptr    [NUM_SRC];
  logic [CNT_W-1:0]  count     [NUM_SRC];
  logic [SRC_W-1:0]  rr_ptr;

  logic [NUM_SRC-1:0] empty, full, cand, grant, byp, push, pop;
  logic [TAG_W-1:0]   cand_tag  [NUM_SRC];
  logic [DATA_W-1:0]  cand_data [NUM_SRC];
  logic [NUM_BUS-1:0] lane_grant;
  logic [SRC_W-1:0]   lane_src  [NUM_BUS];
  logic [TAG_W-1:0]   lane_tag  [NUM_BUS];
  logic [DATA_W-1:0]  lane_data [NUM_BUS];
  logic [SRC_W-1:0]   rr_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      empty[i]     = (count[i] == '0);
      full[i]      = (count[i] == CNT_W'(FIFO_DEPTH));
      src_ready[i] = ~full[i] & ~flush & rst;
      cand[i]      = ~empty[i];
      cand_tag[i]  = fifo_tag[i][rd_ptr[i]];
      cand_data[i] = fifo_data[i][rd_ptr[i]];
`ifdef CDB_BYPASS_EN
      // An empty FIFO offers the result arriving this cycle instead of its (stale) head.
      if (empty[i]) begin
        cand[i]      = src_valid[i] & src_ready[i];
        cand_tag[i]  = src_tag[i];
        cand_data[i] = src_data[i];
      end
`endif
    end
  end

  // Round-robin scan from rr_ptr; the n-th candidate found drives lane n.
  always_comb begin : arb
    int n;
    n          = 0;
    grant      = '0;
    lane_grant = '0;
    rr_next    = rr_ptr;
    for (int k = 0; k < NUM_BUS; k++) lane_src[k] = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if ((i == (int'(rr_ptr) + j) % NUM_SRC) && cand[i] && (n < NUM_BUS)) begin
          grant[i] = 1'b1;
          for (int k = 0; k < NUM_BUS; k++) begin
            if (k == n) begin
              lane_grant[k] = 1'b1;
              lane_src[k]   = SRC_W'(i);
            end
          end
          rr_next = SRC_W'((i + 1) % NUM_SRC);
          n = n + 1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_BUS; k++) begin
      lane_tag[k]  = cand_tag[lane_src[k]];
      lane_data[k] = cand_data[lane_src[k]];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      byp[i]  = grant[i] & empty[i];
      pop[i]  = grant[i] & ~empty[i];
      push[i] = src_valid[i] & src_ready[i] & ~byp[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      bus_valid <= '0;
      bus_tag   <= '0;
      bus_data  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      bus_valid <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      rr_ptr    <= rr_next;
      bus_valid <= lane_grant;
      for (int k = 0; k < NUM_BUS; k++) begin
        if (lane_grant[k]) begin
          bus_tag[k]  <= lane_tag[k];
          bus_data[k] <= lane_data[k];
        end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        fifo_tag[i][wr_ptr[i]]  <= src_tag[i];
        fifo_data[i][wr_ptr[i]] <= src_data[i];
      end
    end
  end

  always_comb begin
    rob_set_valid = '0;
    for (int k = 0; k < NUM_BUS; k++) begin
      if (bus_valid[k]) rob_set_valid[bus_tag[k]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_cdb_arbiter;
  localparam int NUM_SRC    = 6;
  localparam int NUM_BUS    = 2;
  localparam int ROB_DEPTH  = 8;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int TAG_W      = $clog2(ROB_DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [NUM_SRC-1:0]             src_valid = '0;
  logic [NUM_SRC-1:0]             src_ready;
  logic [NUM_SRC-1:0][TAG_W-1:0]  src_tag = '0;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_data = '0;
  logic [NUM_BUS-1:0]             bus_valid;
  logic [NUM_BUS-1:0][TAG_W-1:0]  bus_tag;
  logic [NUM_BUS-1:0][DATA_W-1:0] bus_data;
  logic [ROB_DEPTH-1:0]           rob_set_valid;

  cdb_arbiter #(.NUM_SRC(NUM_SRC), .NUM_BUS(NUM_BUS), .ROB_DEPTH(ROB_DEPTH),
                .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_tag(src_tag), .src_data(src_data),
    .bus_valid(bus_valid), .bus_tag(bus_tag), .bus_data(bus_data),
    .rob_set_valid(rob_set_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t               mq [NUM_SRC][$];
  int                 rr_m;
  logic [NUM_BUS-1:0] exp_bv;
  logic [TAG_W-1:0]   exp_tag  [NUM_BUS];
  logic [DATA_W-1:0]  exp_data [NUM_BUS];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [ROB_DEPTH-1:0] exp_rob();
    logic [ROB_DEPTH-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_BUS; k++) if (exp_bv[k]) r[exp_tag[k]] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
    rr_m   = 0;
    exp_bv = '0;
    for (int k = 0; k < NUM_BUS; k++) begin
      exp_tag[k]  = '0;
      exp_data[k] = '0;
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk($sformatf("%s.bus_valid", ctx), 64'(bus_valid), 64'(exp_bv));
    for (int k = 0; k < NUM_BUS; k++) begin
      chk($sformatf("%s.bus_tag%0d", ctx, k), 64'(bus_tag[k]), 64'(exp_tag[k]));
      chk($sformatf("%s.bus_data%0d", ctx, k), 64'(bus_data[k]), 64'(exp_data[k]));
    end
    chk($sformatf("%s.rob_set_valid", ctx), 64'(rob_set_valid), 64'(exp_rob()));
  endtask

  // One clock: drive inputs, check ready, advance the model, clock, check outputs.
  task automatic cycle(input logic [NUM_SRC-1:0] v, input logic fl, input string ctx);
    logic [NUM_SRC-1:0] rdy, byp;
    int n, last, idx;
    ent_t e;
    src_valid = v;
    flush     = fl;
    #1;
    for (int i = 0; i < NUM_SRC; i++) rdy[i] = !fl && (mq[i].size() < FIFO_DEPTH);
    chk($sformatf("%s.src_ready", ctx), 64'(src_ready), 64'(rdy));
    byp = '0;
    if (fl) begin
      for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
      exp_bv = '0;
    end else begin
      n = 0;
      last = -1;
      exp_bv = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
        idx = (rr_m + j) % NUM_SRC;
        if (n < NUM_BUS) begin
          if (mq[idx].size() > 0) begin
            e = mq[idx].pop_front();
            exp_bv[n] = 1'b1; exp_tag[n] = e.tag; exp_data[n] = e.data;
            n++; last = idx;
          end
`ifdef CDB_BYPASS_EN
          else if (v[idx] && rdy[idx]) begin
            exp_bv[n] = 1'b1; exp_tag[n] = src_tag[idx]; exp_data[n] = src_data[idx];
            byp[idx] = 1'b1;
            n++; last = idx;
          end
`endif
        end
      end
      if (last >= 0) rr_m = (last + 1) % NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++)
        if (v[i] && rdy[i] && !byp[i]) mq[i].push_back('{tag: src_tag[i], data: src_data[i]});
    end
    @(posedge clk);
    #1;
    src_valid = '0;
    flush     = 1'b0;
    check_outputs(ctx);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("reset.src_ready", 64'(src_ready), 64'(0));
    check_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // All six producers push tags 0..5 at once; expect pairs (0,1),(2,3),(4,5).
    for (int i = 0; i < NUM_SRC; i++) begin
      src_tag[i]  = TAG_W'(i);
      src_data[i] = 32'h1000 + 32'(i);
    end
    cycle('1, 1'b0, "all6");
    for (int c = 0; c < 4; c++) cycle('0, 1'b0, "all6_drain");

    // Single push from producer 2.
    src_tag[2]  = 3'd5;
    src_data[2] = 32'hDEADBEEF;
    cycle(6'b000100, 1'b0, "single");
`ifdef CDB_BYPASS_EN
    chk("single.early_valid", 64'(bus_valid), 64'h1);
`else
    chk("single.early_valid", 64'(bus_valid), 64'h0);
    cycle('0, 1'b0, "single_bus");
`endif
    chk("single.lane0_tag", 64'(bus_tag[0]), 64'd5);
    chk("single.lane0_data", 64'(bus_data[0]), 64'hDEADBEEF);
    chk("single.rob", 64'(rob_set_valid), 64'h20);
    cycle('0, 1'b0, "single_after");
    chk("single.after_valid", 64'(bus_valid), 64'h0);

    // Four buffered results flushed; handshakes in the flush cycle are discarded.
    for (int i = 0; i < NUM_SRC; i++) begin
      src_tag[i]  = TAG_W'(i + 2);
      src_data[i] = 32'hF000 + 32'(i);
    end
    cycle(6'b001111, 1'b0, "pre_flush");
    cycle('1, 1'b1, "flush");
    chk("flush.rob", 64'(rob_set_valid), 64'h0);
    for (int c = 0; c < 3; c++) cycle('0, 1'b0, "post_flush");

    // Reset asserted between edges while traffic is buffered.
    for (int i = 0; i < NUM_SRC; i++) src_data[i] = $urandom;
    cycle('1, 1'b0, "pre_rst");
    rst = 1'b0;
    #1;
    chk("midrst.bus_valid", 64'(bus_valid), 64'h0);
    chk("midrst.rob", 64'(rob_set_valid), 64'h0);
    chk("midrst.src_ready", 64'(src_ready), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("in_rst");
    rst = 1'b1;
    src_tag[4]  = 3'd3;
    src_data[4] = 32'h00C0FFEE;
    cycle(6'b010000, 1'b0, "post_rst");
    for (int c = 0; c < 2; c++) cycle('0, 1'b0, "post_rst_drain");

    // Random traffic with occasional flushes.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src_tag[i]  = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
        src_data[i] = $urandom;
      end
      cycle(NUM_SRC'($urandom), ($urandom_range(0, 39) == 0), "rand");
    end

    // Every producer saturated for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src_tag[i]  = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
        src_data[i] = {8'(c), 8'(i), 16'($urandom)};
      end
      cycle('1, 1'b0, "sat");
    end
    for (int c = 0; c < 8; c++) cycle('0, 1'b0, "final_drain");
    chk("final.bus_valid", 64'(bus_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus arbiter for the Tomasulo core. It sits between the execution producers (ALU reservation stations, branch unit, LSQ) and the ROB/reservation-station snoop ports. It replaces the one-slot-per-tag broadcast with a fixed number of physical bus lanes, per-producer skid FIFOs, round-robin lane allocation and a per-cycle ROB "result valid" bitmap. It lets producer count, lane count and ROB depth scale independently.

## Interface
Parameters:
- NUM_SRC, 6, number of producers
- NUM_BUS, 2, broadcast lanes per cycle (1..NUM_SRC)
- ROB_DEPTH, 8, ROB entries (power of two); TAG_W = $clog2(ROB_DEPTH)
- DATA_W, 32, result width
- FIFO_DEPTH, 2, entries per producer FIFO (power of two, >=1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush of all buffered results
- src_valid  in  NUM_SRC  producer i has a result
- src_ready  out  NUM_SRC  producer i FIFO can accept
- src_tag  in  NUM_SRC x TAG_W  ROB tag of result
- src_data  in  NUM_SRC x DATA_W  result value
- bus_valid  out  NUM_BUS  lane k carries a result this cycle
- bus_tag  out  NUM_BUS x TAG_W  lane k tag
- bus_data  out  NUM_BUS x DATA_W  lane k value
- rob_set_valid  out  ROB_DEPTH  bit t set when any valid lane carries tag t

## Operation
- Handshake: transfer on src_valid[i] & src_ready[i] at a rising edge. src_ready[i] = ~fifo_full[i] & ~flush & rst; depends on state, never on src_valid.
- Each FIFO is in-order; results from one producer broadcast in acceptance order.
- Arbitration (combinational, each cycle): candidates are non-empty FIFO heads. Scan indices rr_ptr, rr_ptr+1, ... mod NUM_SRC; the first NUM_BUS candidates found are granted, the n-th grant going to lane n. Granted heads pop at the edge.
- rr_ptr: reset 0; after an edge with >=1 grant, becomes (last granted index + 1) mod NUM_SRC; unchanged if no grants.
- Bus lanes are registered: at each edge bus_valid[k] <= lane k granted; tag/data load only when granted, otherwise hold.
- rob_set_valid: decoded combinationally from registered bus_valid/bus_tag. Duplicate tags across lanes OR together. Producers must never issue the same tag twice while it is in flight; this is not checked.
- flush sampled high at an edge: all FIFOs emptied, bus_valid <= 0, no pops/grants, any handshake that cycle discarded. rr_ptr holds.
- Reset (rst low, asynchronous): FIFOs empty, rr_ptr 0, bus_valid 0, bus_tag 0, bus_data 0, src_ready 0, rob_set_valid 0. src_ready rises the first cycle rst is high.

## Timing
- Default latency: handshake at edge E -> FIFO head in cycle E..E+1 -> granted, lanes load at edge E+1 -> bus_valid visible after E+1 (2 edges).
- Bus never stalls; each lane holds a result for exactly one cycle.
- FIFO full: src_ready low the cycle after the filling push; a push and a pop at the same edge on a full FIFO is legal only if ready was high (it was not), so full FIFOs only drain.
- Throughput: NUM_BUS results/cycle aggregate; with all producers saturated each gets NUM_BUS/NUM_SRC.
- Wrap-around: rr_ptr and FIFO pointers wrap modulo size, no bubble.

## Configuration
- CDB_BYPASS_EN defined: a producer whose FIFO is empty also presents its incoming src_valid/src_tag/src_data as a candidate. If granted, the result goes straight to the lane register at the handshake edge E (1-edge latency) and is not written to the FIFO. If not granted, it enqueues normally. src_ready is unchanged.
- Undefined: no bypass; 2-edge minimum latency as above.

## Test plan
- Single push, src 2, tag 5, data 0xDEADBEEF at edge 10, no other traffic -> cycle after edge 11: bus_valid=2'b01, bus_tag[0]=5, bus_data[0]=0xDEADBEEF, rob_set_valid=8'h20; next cycle all 0.
- All 6 producers push one result each at the same edge (tags 0..5), NUM_BUS=2 -> lanes carry (0,1), (2,3), (4,5) on three consecutive cycles; rr_ptr back to 0.
- Producers 0..5 push every cycle for 20 cycles -> src_ready toggles per FIFO_DEPTH=2; every accepted tag is broadcast exactly once, per-producer order preserved, no grant starvation beyond 3 cycles.
- Four results buffered, flush high one cycle -> next cycle bus_valid=0, rob_set_valid=0, all src_ready=1, and the flushed tags never appear.
- rst driven low mid-stream, between edges -> bus_valid, rob_set_valid and src_ready go 0 immediately; after release, the first push broadcasts with normal latency from lane 0.
- With CDB_BYPASS_EN defined, repeat the first test -> result visible after edge 10 (one cycle earlier); with contention, ungranted bypass candidates enqueue and broadcast later.
